// File: rtl/uub_axil_pkg.sv
// Shared constants, FSM state types and the byte-strobe merge helper
// for the UUB AXI4-Lite register bank.
package uub_axil_pkg;

    localparam logic [1:0]  RESP_OKAY = 2'b00;
    localparam int unsigned ADDR_LSB  = 2;
    localparam int unsigned NUM_REGS  = 4;

    localparam logic [1:0] REG_CTRL0 = 2'd0;
    localparam logic [1:0] REG_CTRL1 = 2'd1;
    localparam logic [1:0] REG_CTRL2 = 2'd2;
    localparam logic [1:0] REG_CTRL3 = 2'd3;

    typedef enum logic [0:0] {WrIdle, WrResp} wr_state_e;
    typedef enum logic [0:0] {RdIdle, RdData} rd_state_e;

    function automatic logic [31:0] strb_merge(input logic [31:0] old_word,
                                               input logic [31:0] wr_word,
                                               input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = wr_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/uub_axil_regbank_if.sv
// AXI4-Lite S00_AXI bus bundle; master drives requests, slave returns readies/responses.
interface uub_axil_regbank_if #(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR;
    logic [2:0]                        S_AXI_AWPROT;
    logic                              S_AXI_AWVALID;
    logic                              S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB;
    logic                              S_AXI_WVALID;
    logic                              S_AXI_WREADY;
    logic [1:0]                        S_AXI_BRESP;
    logic                              S_AXI_BVALID;
    logic                              S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR;
    logic [2:0]                        S_AXI_ARPROT;
    logic                              S_AXI_ARVALID;
    logic                              S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA;
    logic [1:0]                        S_AXI_RRESP;
    logic                              S_AXI_RVALID;
    logic                              S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

endinterface

// File: rtl/uub_axil_regbank.sv
// AXI4-Lite slave with four 32-bit control registers and per-register write pulses.
// Independent write (IDLE/RESP with AW/W holding flags) and read (IDLE/DATA) FSMs.
module uub_axil_regbank
    import uub_axil_pkg::*;
#(
    parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
    parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    uub_axil_regbank_if.slave             s_axi,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
    output logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
    output logic [NUM_REGS-1:0]           reg_wr_pulse
);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic                          aw_full_q, aw_full_d;
    logic                          w_full_q, w_full_d;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic [31:0]                   wdata_q, wdata_d;
    logic [3:0]                    wstrb_q, wstrb_d;
    logic [31:0]                   regs_q [NUM_REGS];
    logic [31:0]                   regs_d [NUM_REGS];
    logic [31:0]                   rdata_q, rdata_d;
    logic [NUM_REGS-1:0]           pulse_q, pulse_d;

    logic                          aw_hs, w_hs;
    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [31:0]                   wr_data;
    logic [3:0]                    wr_strb;
    logic [1:0]                    wr_idx;
    logic [1:0]                    rd_idx;
    logic                          unused_bits;

    assign s_axi.S_AXI_AWREADY = !aw_full_q && (wr_state_q == WrIdle);
    assign s_axi.S_AXI_WREADY  = !w_full_q && (wr_state_q == WrIdle);
    assign s_axi.S_AXI_BVALID  = (wr_state_q == WrResp);
    assign s_axi.S_AXI_BRESP   = RESP_OKAY;
    assign s_axi.S_AXI_ARREADY = (rd_state_q == RdIdle);
    assign s_axi.S_AXI_RVALID  = (rd_state_q == RdData);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = RESP_OKAY;

    assign aw_hs = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;

    // A held beat takes priority; otherwise use the one handshaking this edge.
    assign wr_addr = aw_full_q ? awaddr_q : s_axi.S_AXI_AWADDR;
    assign wr_data = w_full_q ? wdata_q : s_axi.S_AXI_WDATA;
    assign wr_strb = w_full_q ? wstrb_q : s_axi.S_AXI_WSTRB;
    assign wr_idx  = wr_addr[ADDR_LSB +: 2];
    assign rd_idx  = s_axi.S_AXI_ARADDR[ADDR_LSB +: 2];

    // Low/high address bits and PROT are don't-care by design.
    assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, wr_addr,
                           s_axi.S_AXI_ARADDR};

    always_comb begin
        wr_state_d = wr_state_q;
        aw_full_d  = aw_full_q;
        w_full_d   = w_full_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        pulse_d    = '0;
        regs_d     = regs_q;
        unique case (wr_state_q)
            WrIdle: begin
                if ((aw_full_q || aw_hs) && (w_full_q || w_hs)) begin
                    regs_d[wr_idx]  = strb_merge(regs_q[wr_idx], wr_data, wr_strb);
                    pulse_d[wr_idx] = 1'b1;
                    aw_full_d       = 1'b0;
                    w_full_d        = 1'b0;
                    wr_state_d      = WrResp;
                end else begin
                    if (aw_hs) begin
                        aw_full_d = 1'b1;
                        awaddr_d  = s_axi.S_AXI_AWADDR;
                    end
                    if (w_hs) begin
                        w_full_d = 1'b1;
                        wdata_d  = s_axi.S_AXI_WDATA;
                        wstrb_d  = s_axi.S_AXI_WSTRB;
                    end
                end
            end
            WrResp: begin
                if (s_axi.S_AXI_BREADY) begin
                    wr_state_d = WrIdle;
                end
            end
            default: wr_state_d = WrIdle;
        endcase
    end

    // Read samples regs_q, so a same-edge write commit returns the old value.
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        unique case (rd_state_q)
            RdIdle: begin
                if (s_axi.S_AXI_ARVALID) begin
                    rdata_d    = regs_q[rd_idx];
                    rd_state_d = RdData;
                end
            end
            RdData: begin
                if (s_axi.S_AXI_RREADY) begin
                    rd_state_d = RdIdle;
                end
            end
            default: rd_state_d = RdIdle;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            wr_state_q <= WrIdle;
            rd_state_q <= RdIdle;
            aw_full_q  <= 1'b0;
            w_full_q   <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            pulse_q    <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_full_q  <= aw_full_d;
            w_full_q   <= w_full_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            pulse_q    <= pulse_d;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign slv_reg0     = regs_q[REG_CTRL0];
    assign slv_reg1     = regs_q[REG_CTRL1];
    assign slv_reg2     = regs_q[REG_CTRL2];
    assign slv_reg3     = regs_q[REG_CTRL3];
    assign reg_wr_pulse = pulse_q;

endmodule

// File: tb/tb_uub_axil_regbank.sv
// Directed bench for uub_axil_regbank: hand-computed expectations checked with
// immediate assertions, stimulus as one linear sequence.
module tb_uub_axil_regbank;

    logic        tb_ACLK;
    logic        tb_ARESETN;
    logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
    logic [3:0]  reg_wr_pulse;
    int          n_cmp;
    int          n_err;

    uub_axil_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4)) bus ();

    uub_axil_regbank #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4)
    ) dut (
        .S_AXI_ACLK   (tb_ACLK),
        .S_AXI_ARESETN(tb_ARESETN),
        .s_axi        (bus),
        .slv_reg0     (slv_reg0),
        .slv_reg1     (slv_reg1),
        .slv_reg2     (slv_reg2),
        .slv_reg3     (slv_reg3),
        .reg_wr_pulse (reg_wr_pulse)
    );

    initial tb_ACLK = 1'b0;
    always #5 tb_ACLK = ~tb_ACLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // AW and W together with BREADY high; checks B response and the write pulse.
    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [3:0] exp_pulse);
        int n;
        bus.S_AXI_AWADDR  = addr;
        bus.S_AXI_WDATA   = data;
        bus.S_AXI_WSTRB   = strb;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        n = 0;
        @(negedge tb_ACLK);
        while (!(bus.S_AXI_AWREADY && bus.S_AXI_WREADY) && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 20) check("wr_timeout", 32'd0, 32'd1);
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        check("bvalid_set", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("bresp", {30'd0, bus.S_AXI_BRESP}, 32'd0);
        check("wr_pulse", {28'd0, reg_wr_pulse}, {28'd0, exp_pulse});
        @(posedge tb_ACLK); #1;
        check("bvalid_clr", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("pulse_clr", {28'd0, reg_wr_pulse}, 32'd0);
    endtask

    task automatic axi_read(input logic [3:0] addr, input logic [31:0] exp);
        int n;
        bus.S_AXI_ARADDR  = addr;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b1;
        n = 0;
        @(negedge tb_ACLK);
        while (!bus.S_AXI_ARREADY && n < 20) begin
            @(negedge tb_ACLK);
            n++;
        end
        if (n >= 20) check("rd_timeout", 32'd0, 32'd1);
        @(posedge tb_ACLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        check("rvalid_set", {31'd0, bus.S_AXI_RVALID}, 32'd1);
        check("rresp", {30'd0, bus.S_AXI_RRESP}, 32'd0);
        check("rdata", bus.S_AXI_RDATA, exp);
        @(posedge tb_ACLK); #1;
        check("rvalid_clr", {31'd0, bus.S_AXI_RVALID}, 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        tb_ARESETN        = 1'b0;
        bus.S_AXI_AWADDR  = '0;
        bus.S_AXI_AWPROT  = '0;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA   = '0;
        bus.S_AXI_WSTRB   = '0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY  = 1'b1;
        bus.S_AXI_ARADDR  = '0;
        bus.S_AXI_ARPROT  = '0;
        bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY  = 1'b1;
        repeat (3) @(posedge tb_ACLK);
        #1 tb_ARESETN = 1'b1;

        // Reset state
        @(negedge tb_ACLK);
        check("rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        check("rst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
        check("rst_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd1);
        check("rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("rst_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd0);
        check("rst_rdata", bus.S_AXI_RDATA, 32'd0);
        check("rst_reg0", slv_reg0, 32'd0);
        check("rst_reg3", slv_reg3, 32'd0);
        check("rst_pulse", {28'd0, reg_wr_pulse}, 32'd0);
        @(posedge tb_ACLK); #1;

        // Basic write + readback of each register
        axi_write(4'h0, 32'h0101FFFF, 4'hF, 4'b0001);
        axi_read(4'h0, 32'h0101FFFF);
        axi_write(4'h4, 32'hABCD0001, 4'hF, 4'b0010);
        axi_read(4'h4, 32'hABCD0001);
        axi_write(4'h8, 32'hDEAD0011, 4'hF, 4'b0100);
        axi_read(4'h8, 32'hDEAD0011);
        axi_write(4'hC, 32'hBEEF0011, 4'hF, 4'b1000);
        axi_read(4'hC, 32'hBEEF0011);

        // W three cycles ahead of AW
        bus.S_AXI_BREADY = 1'b1;
        bus.S_AXI_WDATA  = 32'h12345678;
        bus.S_AXI_WSTRB  = 4'hF;
        bus.S_AXI_WVALID = 1'b1;
        @(negedge tb_ACLK);
        check("wfirst_wready", {31'd0, bus.S_AXI_WREADY}, 32'd1);
        @(posedge tb_ACLK); #1;
        bus.S_AXI_WVALID = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge tb_ACLK);
            check("wfirst_wready_lo", {31'd0, bus.S_AXI_WREADY}, 32'd0);
            check("wfirst_no_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);
            check("wfirst_reg1_old", slv_reg1, 32'hABCD0001);
        end
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWADDR  = 4'h4;
        bus.S_AXI_AWVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        check("wfirst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("wfirst_reg1", slv_reg1, 32'h12345678);
        check("wfirst_pulse", {28'd0, reg_wr_pulse}, 32'h2);
        @(posedge tb_ACLK); #1;
        check("wfirst_single_b", {31'd0, bus.S_AXI_BVALID}, 32'd0);

        // Partial strobe on reg2
        axi_write(4'h8, 32'hFFFFFFFF, 4'b0101, 4'b0100);
        check("strb_reg2", slv_reg2, 32'hDEFF00FF);
        axi_read(4'h8, 32'hDEFF00FF);

        // BREADY low holds BVALID and blocks a second AW
        bus.S_AXI_AWADDR  = 4'h0;
        bus.S_AXI_WDATA   = 32'h0000AAAA;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_BREADY  = 1'b0;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_WDATA   = 32'h00005555;
        for (int i = 0; i < 5; i++) begin
            @(negedge tb_ACLK);
            check("bstall_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
            check("bstall_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd0);
            check("bstall_wready", {31'd0, bus.S_AXI_WREADY}, 32'd0);
            check("bstall_reg0", slv_reg0, 32'h0000AAAA);
        end
        @(posedge tb_ACLK); #1;
        bus.S_AXI_BREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        check("bstall_b_done", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("bstall_reg0_kept", slv_reg0, 32'h0000AAAA);
        bus.S_AXI_WVALID = 1'b1;
        @(negedge tb_ACLK);
        check("bstall_awready_back", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        check("second_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd1);
        check("second_reg0", slv_reg0, 32'h00005555);
        @(posedge tb_ACLK); #1;

        // RREADY low for 4 cycles on reg3, then an unaligned alias read
        bus.S_AXI_ARADDR  = 4'hC;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_ARVALID = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tb_ACLK);
            check("rstall_rvalid", {31'd0, bus.S_AXI_RVALID}, 32'd1);
            check("rstall_rdata", bus.S_AXI_RDATA, 32'hBEEF0011);
            check("rstall_arready", {31'd0, bus.S_AXI_ARREADY}, 32'd0);
        end
        @(posedge tb_ACLK); #1;
        bus.S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        check("rstall_done", {31'd0, bus.S_AXI_RVALID}, 32'd0);
        axi_read(4'hE, 32'hBEEF0011);

        // Same-edge write commit and read of reg3 returns the old value
        bus.S_AXI_AWADDR  = 4'hC;
        bus.S_AXI_WDATA   = 32'h11112222;
        bus.S_AXI_WSTRB   = 4'hF;
        bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WVALID  = 1'b1;
        bus.S_AXI_ARADDR  = 4'hC;
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_BREADY  = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_ARVALID = 1'b0;
        check("rw_same_rdata_old", bus.S_AXI_RDATA, 32'hBEEF0011);
        check("rw_same_reg3_new", slv_reg3, 32'h11112222);
        bus.S_AXI_RREADY = 1'b1;
        @(posedge tb_ACLK); #1;
        axi_read(4'hC, 32'h11112222);

        // Reset while AW held without W
        bus.S_AXI_AWADDR  = 4'h4;
        bus.S_AXI_AWVALID = 1'b1;
        @(posedge tb_ACLK); #1;
        bus.S_AXI_AWVALID = 1'b0;
        tb_ARESETN = 1'b0;
        repeat (2) @(posedge tb_ACLK);
        #1 tb_ARESETN = 1'b1;
        @(negedge tb_ACLK);
        check("mid_rst_reg0", slv_reg0, 32'd0);
        check("mid_rst_reg1", slv_reg1, 32'd0);
        check("mid_rst_reg2", slv_reg2, 32'd0);
        check("mid_rst_reg3", slv_reg3, 32'd0);
        check("mid_rst_bvalid", {31'd0, bus.S_AXI_BVALID}, 32'd0);
        check("mid_rst_awready", {31'd0, bus.S_AXI_AWREADY}, 32'd1);
        @(posedge tb_ACLK); #1;
        axi_write(4'h8, 32'hCAFEF00D, 4'hF, 4'b0100);
        check("post_rst_reg1", slv_reg1, 32'd0);
        axi_read(4'h8, 32'hCAFEF00D);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
